rap_err_recover: RTL

- Downstream stage of the 32-bit reduced-carry approximate adder.
- Takes the operands and the adder's 33-bit approximate sum. Detects exactly whether the speculative carry window (5 bits: bit i sees generates in i..i-4) missed a carry.
- Clean results pass through in 1 cycle. Erroneous results are rebuilt by a multi-cycle chunked exact adder, unless correction is disabled.
- Also keeps a saturating error-event counter for accuracy profiling.

---
 rtl/rap_pkg.sv | 31 +++
 rtl/rap_err_detect.sv | 27 ++
 rtl/rap_err_recover.sv | 120 ++++++++++++
 3 files changed

// File: rtl/rap_pkg.sv
// Shared definitions for the reduced-carry approximate adder and its recovery stage.
package rap_pkg;

    localparam int RAP_W   = 32;
    localparam int RAP_WIN = 5;

    typedef enum logic {IDLE, CORR} rap_state_e;

    // Carry out of bit i built only from generates/propagates in bits i..i-RAP_WIN+1.
    function automatic logic [RAP_W-1:0] rap_appc(input logic [RAP_W-1:0] a,
                                                  input logic [RAP_W-1:0] b);
        logic [RAP_W-1:0] p;
        logic [RAP_W-1:0] g;
        logic [RAP_W-1:0] c;
        logic             run;
        p = a ^ b;
        g = a & b;
        for (int i = 0; i < RAP_W; i++) begin
            c[i] = 1'b0;
            run  = 1'b1;
            for (int k = 0; k < RAP_WIN; k++) begin
                if (i - k >= 0) begin
                    c[i] = c[i] | (run & g[i-k]);
                    run  = run & p[i-k];
                end
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/rap_err_detect.sv
// Exact detection of a carry missed by the speculative window: a full-window
// propagate run fed by a carry the window below did produce.
module rap_err_detect
    import rap_pkg::*;
(
    input  logic [RAP_W-1:0] a,
    input  logic [RAP_W-1:0] b,
    output logic             err
);

    logic [RAP_W-1:0] p;
    logic [RAP_W-1:0] appc;
    logic             unused_appc_hi;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        p    = a ^ b;
        appc = rap_appc(a, b);
        err  = 1'b0;
        for (int i = RAP_WIN; i < RAP_W; i++) begin
            err = err | ((&p[i -: RAP_WIN]) & appc[i-RAP_WIN]);
        end
    end

    assign unused_appc_hi = ^appc[RAP_W-1:RAP_W-RAP_WIN];

endmodule

// File: rtl/rap_err_recover.sv
// Recovery stage: passes clean approximate sums in one cycle, rebuilds wrong ones
// with a chunked exact adder over NCH cycles, and counts detected errors.
module rap_err_recover
    import rap_pkg::*;
#(
    parameter int CHUNK      = 8,
    parameter int CORRECT_EN = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RAP_W-1:0] in_a,
    input  logic [RAP_W-1:0] in_b,
    input  logic [RAP_W:0]   in_appx_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RAP_W:0]   out_sum,
    output logic             out_err,
    output logic             out_corrected,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             cnt_clr
);

    localparam int NCH   = RAP_W / CHUNK;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    rap_state_e       state;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [RAP_W-1:0] a_q;
    logic [RAP_W-1:0] b_q;
    logic [RAP_W-1:0] res;
    logic [RAP_W-1:0] res_next;
    logic [CHUNK:0]   csum;
    logic             err;
    logic             accept;

    rap_err_detect u_det (
        .a   (in_a),
        .b   (in_b),
        .err (err)
    );

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        csum = {1'b0, a_q[int'(idx)*CHUNK +: CHUNK]}
             + {1'b0, b_q[int'(idx)*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, carry};
        res_next = res;
        res_next[int'(idx)*CHUNK +: CHUNK] = csum[CHUNK-1:0];
    end

    // NOTE: datapath registers are reset too; they are few and it keeps outputs deterministic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            carry         <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            res           <= '0;
            out_valid     <= 1'b0;
            out_sum       <= '0;
            out_err       <= 1'b0;
            out_corrected <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            case (state)
                IDLE: begin
                    if (out_valid && out_ready) out_valid <= 1'b0;
                    if (accept) begin
                        if (err && (CORRECT_EN != 0)) begin
                            a_q   <= in_a;
                            b_q   <= in_b;
                            idx   <= '0;
                            carry <= 1'b0;
                            state <= CORR;
                        end else begin
                            out_valid     <= 1'b1;
                            out_sum       <= in_appx_sum;
                            out_err       <= err;
                            out_corrected <= 1'b0;
                        end
                    end
                end
                CORR: begin
                    res   <= res_next;
                    carry <= csum[CHUNK];
                    if (idx == IDX_W'(NCH-1)) begin
                        out_valid     <= 1'b1;
                        out_sum       <= {csum[CHUNK], res_next};
                        out_err       <= 1'b1;
                        out_corrected <= 1'b1;
                        idx           <= '0;
                        state         <= IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Clear has priority over a coincident increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (cnt_clr) begin
            err_cnt <= '0;
        end else if (accept && err && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule
